// File: rtl/pool_apply_mc.sv
// Multi-channel pool apply stage: per-channel request FIFOs served round-robin,
// each request expands into len pointer-apply beats followed by one final-apply beat.
module pool_apply_mc #(
  parameter int NUM_CH            = 4,
  parameter int WQE_INDEX_WIDTH   = 10,
  parameter int WQE_SOURCE_LENGTH = 11,
  parameter int FIFO_ADDR_WIDTH   = 7,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IL   = WQE_INDEX_WIDTH + WQE_SOURCE_LENGTH
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [NUM_CH-1:0]            s_axis_Papply_valid,
  input  logic [NUM_CH*IL-1:0]         s_axis_Papply_id_len,
  output logic [NUM_CH-1:0]            s_axis_Papply_ready,
  output logic                         m_axis_Ptrapply_valid,
  input  logic                         m_axis_Ptrapply_ready,
  output logic [WQE_INDEX_WIDTH-1:0]   m_axis_Ptrapply_id,
  output logic [CH_W-1:0]              m_axis_Ptrapply_ch,
  output logic [WQE_SOURCE_LENGTH-1:0] m_axis_Ptrapply_idx,
  output logic                         m_axis_Fapply_valid,
  input  logic                         m_axis_Fapply_ready,
  output logic [WQE_INDEX_WIDTH-1:0]   m_axis_Fapply_id,
  output logic [WQE_SOURCE_LENGTH-1:0] m_axis_Fapply_len,
  output logic [CH_W-1:0]              m_axis_Fapply_ch,
  output logic                         drop_valid,
  output logic [CH_W-1:0]              drop_ch,
  output logic                         busy
);

  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int CNT_W = FIFO_ADDR_WIDTH + 1;
  localparam logic [WQE_SOURCE_LENGTH-1:0] LEN_ONE = WQE_SOURCE_LENGTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_FIN} state_t;

  state_t r_state, w_state_nxt;

  logic [IL-1:0]              r_mem    [NUM_CH][DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr [NUM_CH];
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr [NUM_CH];
  logic [CNT_W-1:0]           r_count  [NUM_CH];

  logic [NUM_CH-1:0] w_empty, w_full, w_wr, w_pop;
  logic              w_grant_vld, w_take, w_last_beat;
  logic [CH_W-1:0]   w_grant_ch;
  logic [IL-1:0]     w_head;
  logic [WQE_SOURCE_LENGTH-1:0] w_head_len;
  logic [WQE_INDEX_WIDTH-1:0]   w_head_id;

  logic [CH_W-1:0]              r_last_grant, r_ch, r_drop_ch;
  logic [WQE_INDEX_WIDTH-1:0]   r_id;
  logic [WQE_SOURCE_LENGTH-1:0] r_len, r_idx;
  logic                         r_drop_valid;

  // Ready is held low during reset so nothing is accepted into a FIFO being cleared.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_wr    = '0;
    s_axis_Papply_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_empty[c] = (r_count[c] == '0);
      w_full[c]  = (r_count[c] == CNT_W'(DEPTH));
      s_axis_Papply_ready[c] = sys_rst_n && !w_full[c];
      w_wr[c] = s_axis_Papply_valid[c] && s_axis_Papply_ready[c];
    end
  end

  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NUM_CH; c++)
      w_pop[c] = w_take && (w_grant_ch == CH_W'(c));
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr[c])  r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
        if (w_pop[c]) r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
        if (w_wr[c] && !w_pop[c])      r_count[c] <= r_count[c] + 1'b1;
        else if (!w_wr[c] && w_pop[c]) r_count[c] <= r_count[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (w_wr[c]) r_mem[c][r_wr_ptr[c]] <= s_axis_Papply_id_len[c*IL +: IL];
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int k;
    k = 0;
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = int'(r_last_grant) + 1 + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      if (!w_grant_vld && !w_empty[CH_W'(k)]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = CH_W'(k);
      end
    end
  end

  assign w_head      = r_mem[w_grant_ch][r_rd_ptr[w_grant_ch]];
  assign w_head_len  = w_head[IL-1:WQE_INDEX_WIDTH];
  assign w_head_id   = w_head[WQE_INDEX_WIDTH-1:0];
  assign w_last_beat = (r_idx == r_len - LEN_ONE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: if (w_grant_vld) begin
        w_take = 1'b1;
        if (w_head_len != '0) w_state_nxt = S_PTR;
      end
      S_PTR:  if (m_axis_Ptrapply_ready && w_last_beat) w_state_nxt = S_FIN;
      S_FIN:  if (m_axis_Fapply_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // idx is one bit too narrow to count past len only when len is maximal,
  // and it stops advancing once the last beat is taken, so it never wraps.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_id         <= '0;
      r_len        <= '0;
      r_ch         <= '0;
      r_idx        <= '0;
      r_drop_valid <= 1'b0;
      r_drop_ch    <= '0;
    end else begin
      r_drop_valid <= 1'b0;
      if (w_take) begin
        r_id         <= w_head_id;
        r_len        <= w_head_len;
        r_ch         <= w_grant_ch;
        r_idx        <= '0;
        r_last_grant <= w_grant_ch;
        if (w_head_len == '0) begin
          r_drop_valid <= 1'b1;
          r_drop_ch    <= w_grant_ch;
        end
      end
      if (r_state == S_PTR && m_axis_Ptrapply_ready && !w_last_beat)
        r_idx <= r_idx + LEN_ONE;
    end
  end

  assign m_axis_Ptrapply_valid = (r_state == S_PTR);
  assign m_axis_Ptrapply_id    = r_id;
  assign m_axis_Ptrapply_ch    = r_ch;
  assign m_axis_Ptrapply_idx   = r_idx;
  assign m_axis_Fapply_valid   = (r_state == S_FIN);
  assign m_axis_Fapply_id      = r_id;
  assign m_axis_Fapply_len     = r_len;
  assign m_axis_Fapply_ch      = r_ch;
  assign drop_valid            = r_drop_valid;
  assign drop_ch               = r_drop_ch;
  assign busy                  = (r_state != S_IDLE);

endmodule

// File: tb/tb_pool_apply_mc.sv
// Bench for pool_apply_mc: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the request service order.
module tb_pool_apply_mc;

  localparam int NCH   = 4;
  localparam int IW    = 10;
  localparam int LW    = 11;
  localparam int CW    = 2;
  localparam int IL    = IW + LW;
  localparam int DEPTH = 128;

  logic              sys_clk, sys_rst_n;
  logic [NCH-1:0]    s_valid, s_ready;
  logic [NCH*IL-1:0] s_id_len;
  logic              ptr_v, ptr_r, fin_v, fin_r, drop_v, busy;
  logic [IW-1:0]     ptr_id, fin_id;
  logic [LW-1:0]     ptr_idx, fin_len;
  logic [CW-1:0]     ptr_ch, fin_ch, drop_ch;

  pool_apply_mc #(
    .NUM_CH(NCH), .WQE_INDEX_WIDTH(IW), .WQE_SOURCE_LENGTH(LW), .FIFO_ADDR_WIDTH(7)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .s_axis_Papply_valid(s_valid), .s_axis_Papply_id_len(s_id_len),
    .s_axis_Papply_ready(s_ready),
    .m_axis_Ptrapply_valid(ptr_v), .m_axis_Ptrapply_ready(ptr_r),
    .m_axis_Ptrapply_id(ptr_id), .m_axis_Ptrapply_ch(ptr_ch), .m_axis_Ptrapply_idx(ptr_idx),
    .m_axis_Fapply_valid(fin_v), .m_axis_Fapply_ready(fin_r),
    .m_axis_Fapply_id(fin_id), .m_axis_Fapply_len(fin_len), .m_axis_Fapply_ch(fin_ch),
    .drop_valid(drop_v), .drop_ch(drop_ch), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: one queue per channel plus the request currently served.
  logic [IL-1:0] mq [NCH][$];
  logic m_srv, m_drop;
  int   m_id, m_len, m_ch, m_idx, m_last, m_drop_ch;

  int n_checks, n_fail, n_acc;
  int cnt_busy, cnt_ptr, cnt_fin, cnt_drop;
  int fin_chs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) mq[k].delete();
    m_srv = 1'b0; m_drop = 1'b0; m_idx = 0; m_len = 0; m_id = 0; m_ch = 0;
    m_last = NCH - 1; m_drop_ch = 0;
  endtask

  function automatic logic [IL-1:0] pk(input int len, input int id);
    logic [IL-1:0] v;
    v = {LW'(len), IW'(id)};
    return v;
  endfunction

  task automatic tick();
    logic [NCH-1:0] rdy;
    logic pv, fv, granted;
    logic [IL-1:0] e;
    int c;
    #1;
    pv = m_srv && (m_idx < m_len);
    fv = m_srv && (m_idx == m_len);
    for (int k = 0; k < NCH; k++) rdy[k] = sys_rst_n && (mq[k].size() < DEPTH);
    chk("s_ready", 32'(s_ready), 32'(rdy));
    chk("ptr_valid", 32'(ptr_v), 32'(pv));
    chk("fin_valid", 32'(fin_v), 32'(fv));
    chk("busy", 32'(busy), 32'(m_srv));
    chk("drop_valid", 32'(drop_v), 32'(m_drop));
    if (pv) begin
      chk("ptr_id", 32'(ptr_id), 32'(m_id));
      chk("ptr_ch", 32'(ptr_ch), 32'(m_ch));
      chk("ptr_idx", 32'(ptr_idx), 32'(m_idx));
    end
    if (fv) begin
      chk("fin_id", 32'(fin_id), 32'(m_id));
      chk("fin_len", 32'(fin_len), 32'(m_len));
      chk("fin_ch", 32'(fin_ch), 32'(m_ch));
    end
    if (m_drop) chk("drop_ch", 32'(drop_ch), 32'(m_drop_ch));
    if (busy === 1'b1) cnt_busy++;
    if (drop_v === 1'b1) cnt_drop++;
    if (ptr_v === 1'b1 && ptr_r) cnt_ptr++;
    if (fin_v === 1'b1 && fin_r) begin
      cnt_fin++;
      fin_chs.push_back(int'(fin_ch));
    end
    if (!sys_rst_n) model_reset();
    else begin
      granted = 1'b0;
      m_drop  = 1'b0;
      if (pv) begin
        if (ptr_r) m_idx++;
      end else if (fv) begin
        if (fin_r) m_srv = 1'b0;
      end else begin
        for (int i = 1; i <= NCH; i++) begin
          c = (m_last + i) % NCH;
          if (!granted && mq[c].size() > 0) begin
            e = mq[c].pop_front();
            granted = 1'b1;
            m_last = c; m_ch = c; m_idx = 0;
            m_id  = int'(e[IW-1:0]);
            m_len = int'(e[IL-1:IW]);
            if (m_len == 0) begin
              m_drop = 1'b1;
              m_drop_ch = c;
            end else m_srv = 1'b1;
          end
        end
      end
      for (int k = 0; k < NCH; k++)
        if (s_valid[k] && rdy[k]) begin
          mq[k].push_back(s_id_len[k*IL +: IL]);
          n_acc++;
        end
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic idle_n(input int n);
    s_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push1(input int ch, input int len, input int id);
    s_valid = '0;
    s_valid[ch] = 1'b1;
    s_id_len[ch*IL +: IL] = pk(len, id);
    tick();
    s_valid = '0;
  endtask

  initial begin
    int acc0, steps;
    logic found;
    n_checks = 0; n_fail = 0; n_acc = 0;
    cnt_busy = 0; cnt_ptr = 0; cnt_fin = 0; cnt_drop = 0;
    s_valid = '0; s_id_len = '0; ptr_r = 1'b1; fin_r = 1'b1; sys_rst_n = 1'b0;
    model_reset();
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_ptr_id", 32'(ptr_id), 0);
    chk("rst_ptr_ch", 32'(ptr_ch), 0);
    chk("rst_ptr_idx", 32'(ptr_idx), 0);
    chk("rst_fin_id", 32'(fin_id), 0);
    chk("rst_fin_len", 32'(fin_len), 0);
    chk("rst_fin_ch", 32'(fin_ch), 0);
    chk("rst_drop_ch", 32'(drop_ch), 0);
    tick();
    sys_rst_n = 1'b1;

    // All four channels at once, then a partial refill.
    fin_chs.delete();
    s_valid = '1;
    for (int c = 0; c < NCH; c++) s_id_len[c*IL +: IL] = pk(1, c);
    tick();
    idle_n(16);
    chk("rr_count", 32'(fin_chs.size()), 4);
    for (int c = 0; c < NCH && c < fin_chs.size(); c++) chk("rr_order", 32'(fin_chs[c]), 32'(c));
    fin_chs.delete();
    s_valid = 4'b0101;
    s_id_len[0*IL +: IL] = pk(1, 16);
    s_id_len[2*IL +: IL] = pk(1, 18);
    tick();
    idle_n(10);
    chk("rr2_count", 32'(fin_chs.size()), 2);
    if (fin_chs.size() == 2) begin
      chk("rr2_first", 32'(fin_chs[0]), 0);
      chk("rr2_second", 32'(fin_chs[1]), 2);
    end

    // Single len=3 request with free-flowing outputs.
    cnt_busy = 0; cnt_ptr = 0; cnt_fin = 0;
    push1(0, 3, 'h05);
    idle_n(8);
    chk("t1_busy_cycles", 32'(cnt_busy), 4);
    chk("t1_ptr_beats", 32'(cnt_ptr), 3);
    chk("t1_fin_beats", 32'(cnt_fin), 1);

    // Pointer-apply backpressure pattern.
    cnt_ptr = 0; cnt_fin = 0;
    push1(1, 2, 'h22);
    for (int i = 0; i < 6; i++) begin
      ptr_r = (i == 0 || i == 3 || i == 5);
      tick();
    end
    ptr_r = 1'b1;
    idle_n(4);
    chk("t3_ptr_beats", 32'(cnt_ptr), 2);
    chk("t3_fin_beats", 32'(cnt_fin), 1);

    // Zero-length drop followed by a normal request.
    cnt_ptr = 0; cnt_drop = 0; cnt_fin = 0;
    push1(1, 0, 'h3FF);
    push1(2, 1, 'h07);
    idle_n(6);
    chk("t4_drop_pulses", 32'(cnt_drop), 1);
    chk("t4_ptr_beats", 32'(cnt_ptr), 1);
    chk("t4_fin_beats", 32'(cnt_fin), 1);

    // Fill channel 2 while the final apply is stalled.
    cnt_fin = 0; acc0 = n_acc;
    fin_r = 1'b0;
    s_valid = 4'b0100;
    for (int i = 0; i < 135; i++) begin
      s_id_len[2*IL +: IL] = pk(1, i);
      tick();
    end
    #1;
    chk("t5_full_ready2", 32'(s_ready[2]), 0);
    chk("t5_other_ready", 32'({s_ready[3], s_ready[1], s_ready[0]}), 32'h7);
    fin_r = 1'b1;
    for (int i = 135; i < 145; i++) begin
      s_id_len[2*IL +: IL] = pk(1, i);
      tick();
    end
    idle_n(460);
    chk("t5_all_served", 32'(cnt_fin), 32'(n_acc - acc0));

    // Maximum length must complete without wrapping.
    cnt_ptr = 0; cnt_fin = 0;
    push1(0, 2047, 'h1AB);
    idle_n(2055);
    chk("t6_max_beats", 32'(cnt_ptr), 2047);
    chk("t6_max_fin", 32'(cnt_fin), 1);

    // Reset in the middle of a long request with other channels queued.
    s_valid = 4'b0111;
    s_id_len[0*IL +: IL] = pk(10, 'h0A);
    s_id_len[1*IL +: IL] = pk(2, 'h11);
    s_id_len[2*IL +: IL] = pk(3, 'h12);
    tick();
    s_valid = '0;
    found = 1'b0; steps = 0;
    while (!found && steps < 40) begin
      if (ptr_v === 1'b1 && ptr_idx == 4) found = 1'b1;
      else begin
        tick();
        steps++;
      end
    end
    chk("t7_reach_idx4", 32'(found), 1);
    sys_rst_n = 1'b0;
    tick();
    #1;
    chk("t7_rst_ptr_v", 32'(ptr_v), 0);
    chk("t7_rst_fin_v", 32'(fin_v), 0);
    chk("t7_rst_ready", 32'(s_ready), 0);
    tick();
    sys_rst_n = 1'b1;
    cnt_fin = 0; fin_chs.delete();
    push1(3, 2, 'h33);
    idle_n(8);
    chk("t7_fresh_fin", 32'(cnt_fin), 1);
    if (fin_chs.size() > 0) chk("t7_fresh_ch", 32'(fin_chs[0]), 3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        s_valid[c] = ($urandom_range(0, 2) == 0);
        s_id_len[c*IL +: IL] = pk($urandom_range(0, 4), $urandom_range(0, 1023));
      end
      ptr_r = ($urandom_range(0, 3) != 0);
      fin_r = ($urandom_range(0, 3) != 0);
      tick();
    end
    ptr_r = 1'b1; fin_r = 1'b1;
    idle_n(600);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_apply_mc.md
# pool_apply_mc

Multi-channel successor to the single-queue pool apply stage. It accepts buffer-allocation requests `{len, id}` from `NUM_CH` independent producers and queues each in a per-channel FIFO. It serves the queues round-robin: each request becomes `len` pointer-apply beats followed by one final-apply beat. It sits between the WQE parsers and the resource-pool pointer allocator / free-list manager.

## Interface
- `NUM_CH`, 4 — number of request channels, 1..16; `CH_W = max(1, clog2(NUM_CH))`
- `WQE_INDEX_WIDTH`, 10 — WQE id width
- `WQE_SOURCE_LENGTH`, 11 — length field width; also the width of the beat index
- `FIFO_ADDR_WIDTH`, 7 — per-channel FIFO depth is `2^FIFO_ADDR_WIDTH`
- Ports below use `IL = WQE_INDEX_WIDTH + WQE_SOURCE_LENGTH`.

Ports. One clock; reset is synchronous and active-low.
- `sys_clk`  in  1  — clock
- `sys_rst_n`  in  1  — synchronous reset, active low
- `s_axis_Papply_valid`  in  NUM_CH  — per-channel request valid
- `s_axis_Papply_id_len`  in  NUM_CH*IL  — channel c occupies bits `[c*IL +: IL]`; within each, `{len[IL-1:WQE_INDEX_WIDTH], id[WQE_INDEX_WIDTH-1:0]}`
- `s_axis_Papply_ready`  out  NUM_CH  — per-channel ready
- `m_axis_Ptrapply_valid` / `_ready`  out/in  1 — pointer-apply handshake
- `m_axis_Ptrapply_id`  out  WQE_INDEX_WIDTH — id of the request being served
- `m_axis_Ptrapply_ch`  out  CH_W — source channel
- `m_axis_Ptrapply_idx`  out  WQE_SOURCE_LENGTH — beat index, 0..len-1
- `m_axis_Fapply_valid` / `_ready`  out/in  1 — final-apply handshake
- `m_axis_Fapply_id`, `_len`, `_ch`  out  WQE_INDEX_WIDTH / WQE_SOURCE_LENGTH / CH_W
- `drop_valid`  out  1 — one-cycle pulse: a zero-length request was discarded
- `drop_ch`  out  CH_W — channel of the dropped request
- `busy`  out  1 — high when state ≠ IDLE

## Operation
- **Per-channel FIFO**
  - Write on `s_valid[c] && s_ready[c]`.
  - `s_ready[c] = !full[c]`, combinational from the FIFO count, so the FIFO accepts one request per cycle per channel.
  - A simultaneous write and pop on the same FIFO is legal.
- **FSM states:** IDLE, PTR, FIN.
- **IDLE**
  - Round-robin arbiter over `!empty[c]`. The search starts at `last_grant+1`, mod NUM_CH. After reset, `last_grant = NUM_CH-1`, so channel 0 has highest priority.
  - On grant: pop the head, register `id`, `len`, `ch`, clear `idx`, update `last_grant`.
  - If `len == 0`: stay in IDLE, pulse `drop_valid` with `drop_ch` the next cycle, emit no beats.
  - Otherwise go to PTR.
  - With no channel pending, stay in IDLE.
- **PTR**
  - `Ptrapply_valid = 1`. id, ch and idx are stable while valid && !ready.
  - On handshake: `idx <= idx + 1`. If `idx == len-1`, go to FIN and deassert Ptrapply valid.
- **FIN**
  - `Fapply_valid = 1` with the registered id, len and ch; held until ready.
  - On handshake, go to IDLE.
- **Exclusivity:** Ptrapply valid and Fapply valid are never high in the same cycle.
- **Arithmetic:** `idx` compare is unsigned at WQE_SOURCE_LENGTH width. The maximum `len = 2^WQE_SOURCE_LENGTH - 1` must not wrap before FIN.

## Timing
- **Reset values:** all `m_*_valid`, `drop_valid`, `busy` = 0. All id/len/ch/idx outputs = 0. FSM = IDLE. FIFOs empty.
- **Ready during reset:** `s_axis_Papply_ready` = 0 while `sys_rst_n` = 0 and 1 after reset releases.
- **Latency:** request accepted at cycle N → FIFO non-empty at N+1 → grant at N+1 → first Ptrapply valid at N+2.
- **Throughput:** with both readies held at 1, a request of length L occupies L+2 cycles (1 IDLE + L PTR + 1 FIN).
- **Backpressure:** valid is never withdrawn before handshake. Payload never changes while valid && !ready.
- **Reset mid-operation:** the in-flight request is abandoned, no further beats are emitted, all FIFO contents are discarded, and the arbiter returns to channel-0 priority.
- **Full boundary:** with `2^FIFO_ADDR_WIDTH` entries stored, `s_ready[c]` = 0 in that cycle. A pop in the same cycle re-raises ready in the next cycle.

## Test plan
- Ch0 request {len=3, id=0x05}, readies = 1 → Ptrapply beats idx 0,1,2 (id 0x05, ch 0) on consecutive cycles starting N+2, then Fapply {0x05, 3, ch0}, `busy` falls after 5 cycles.
- All 4 channels each push {len=1, id=c} in the same cycle → served in order ch0, ch1, ch2, ch3. Then ch0 and ch2 refill → order ch0, ch2 (rotation resumes after ch3).
- Ptrapply_ready toggled 1,0,0,1,0,1 on {len=2} → exactly 2 Ptr beats, payload stable in stalled cycles, no Fapply before the 2nd Ptr handshake.
- Ch1 request {len=0, id=0x3FF} → no Ptr/Fapply beats, `drop_valid` 1 for exactly one cycle with `drop_ch` = 1, next queued request served normally.
- Ch2 holds Fapply_ready = 0 with the FIFO filled to 128 entries → `s_ready[2]` = 0, other channels' readies remain 1, no entry lost or duplicated after release.
- `sys_rst_n` = 0 asserted during PTR idx=4 of {len=10} → next cycle all valids 0, FIFOs empty, `s_ready` = 0; after release, a fresh ch3 request completes normally.
